writeback_queue: RTL

Writeback stage sitting directly upstream of the 64-bit, 32-entry register file: merges single-cycle ALU/load results with results from long-latency units (multiplier/divider) and issues at most one register-file write per cycle. Long-latency results are buffered in a small FIFO with a valid/ready handshake. A per-register pending vector is exported to the hazard unit. X31 (XZR) writes are discarded here so the register file never sees them.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/writeback_queue_if.sv | 25 ++
 rtl/wb_entry_fifo.sv | 64 ++++++
 rtl/writeback_queue.sv | 77 +++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and the writeback queue entry type.
// Imported by the interface, FIFO and top level.
package cpu_pkg;
  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam int RWIDTH = $clog2(NREGS);
  localparam int QDEPTH = 4;
  localparam int ZERO_REG = 31;

  typedef struct packed {
    logic              valid;
    logic [RWIDTH-1:0] sel;
    logic [XLEN-1:0]   data;
  } entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// Long-latency result handshake (valid/ready).
// master: producer (mul/div); slave: writeback queue.
interface writeback_queue_if
  import cpu_pkg::*;
#(
  parameter int BITSIZE = XLEN,
  parameter int REGSIZE = NREGS
) ();
  localparam int RW = $clog2(REGSIZE);

  logic               m_valid;
  logic               m_ready;
  logic [RW-1:0]      m_sel;
  logic [BITSIZE-1:0] m_data;

  modport master (
    output m_valid, m_sel, m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_sel, m_data,
    output m_ready
  );
endinterface

// File: rtl/wb_entry_fifo.sv
// Long-latency result FIFO with per-register squash and pending OR.
// Ports: push/pop controls, squash by index, head, full/empty, count, pend.
module wb_entry_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = QDEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [RWIDTH-1:0] push_sel,
  input  logic [XLEN-1:0]   push_data,
  input  logic              pop,
  input  logic              squash,
  input  logic [RWIDTH-1:0] squash_sel,
  output entry_t            head,
  output logic              empty,
  output logic              full,
  output logic [PW-1:0]     count,
  output logic [NREGS-1:0]  pend
);
  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  // Later assignments win: a same-cycle push is the
  // younger write and must survive the squash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash && mem[i].sel == squash_sel)
          mem[i].valid <= 1'b0;
      if (pop) begin
        mem[rptr[AW-1:0]].valid <= 1'b0;
        rptr <= rptr + PW'(1);
      end
      if (push) begin
        mem[wptr[AW-1:0]] <= '{valid: 1'b1,
                               sel: push_sel,
                               data: push_data};
        wptr <= wptr + PW'(1);
      end
    end
  end

  // Freed slots have valid cleared, so no occupancy gating.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i].valid) pend[mem[i].sel] = 1'b1;
  end
endmodule

// File: rtl/writeback_queue.sv
// Writeback stage: ALU results win, long-latency FIFO fills gaps.
// Ports: clk, rst, a_*, m (slave if), wb_*, pending, count.
module writeback_queue
  import cpu_pkg::*;
#(
  parameter int BITSIZE = XLEN,
  parameter int REGSIZE = NREGS,
  parameter int DEPTH = QDEPTH,
  localparam int RW = $clog2(REGSIZE),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  input  logic [RW-1:0]      a_sel,
  input  logic [BITSIZE-1:0] a_data,
  writeback_queue_if.slave   m,
  output logic               wb_en,
  output logic [RW-1:0]      wb_sel,
  output logic [BITSIZE-1:0] wb_data,
  output logic [REGSIZE-1:0] pending,
  output logic [CW-1:0]      count
);
  entry_t             head;
  logic               empty;
  logic               full;
  logic [REGSIZE-1:0] fpend;
  logic               alu_w;
  logic               push;
  logic               pop;

  assign alu_w     = a_valid && (a_sel != RW'(ZERO_REG));
  assign m.m_ready = !full && !rst;
  assign push      = m.m_valid && m.m_ready &&
                     (m.m_sel != RW'(ZERO_REG));
  assign pop       = !alu_w && !empty;

  wb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_sel   (m.m_sel),
    .push_data  (m.m_data),
    .pop        (pop),
    .squash     (alu_w),
    .squash_sel (a_sel),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .pend       (fpend)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_sel  <= '0;
      wb_data <= '0;
    end else if (alu_w) begin
      wb_en   <= 1'b1;
      wb_sel  <= a_sel;
      wb_data <= a_data;
    end else if (!empty) begin
      wb_en   <= head.valid;
      wb_sel  <= head.sel;
      wb_data <= head.data;
    end else begin
      wb_en   <= 1'b0;
    end
  end

  always_comb begin
    pending = fpend;
    if (wb_en) pending[wb_sel] = 1'b1;
    pending[ZERO_REG] = 1'b0;
  end
endmodule
